// File: rtl/cl_pkg.sv
// Shared definitions for the Camera Link grabber: command opcodes, capture
// FSM encoding, and the layout of the 128-bit pixel message.
package cl_pkg;

   localparam logic [11:0] OP_ABORT = 12'h000;
   localparam logic [11:0] OP_START = 12'h001;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_LOW = 2'd1,
      ST_ARMED    = 2'd2,
      ST_CAPTURE  = 2'd3
   } cl_state_e;

   localparam int MSG_W         = 128;
   localparam int TAP_W         = 40;
   localparam int CNT_W         = 16;
   localparam int MSG_FRAME_LSB = 112;
   localparam int MSG_LINE_LSB  = 96;
   localparam int MSG_COL_LSB   = 80;
   localparam int MSG_BTM_LSB   = 40;
   localparam int MSG_TOP_LSB   = 0;

   function automatic logic [MSG_W-1:0] cl_pack_msg(
      input logic [CNT_W-1:0] frame,
      input logic [CNT_W-1:0] line,
      input logic [CNT_W-1:0] col,
      input logic [TAP_W-1:0] btm,
      input logic [TAP_W-1:0] top
   );
      logic [MSG_W-1:0] m;
      m = '0;
      m[MSG_FRAME_LSB +: CNT_W] = frame;
      m[MSG_LINE_LSB  +: CNT_W] = line;
      m[MSG_COL_LSB   +: CNT_W] = col;
      m[MSG_BTM_LSB   +: TAP_W] = btm;
      m[MSG_TOP_LSB   +: TAP_W] = top;
      return m;
   endfunction

endpackage

// File: rtl/cl_cmd_sync.sv
// Moves one 32-bit command word from bus_clk to cl_clk with a toggle
// handshake. The word is held static in the bus domain while a command is in
// flight, so the cl_clk side may read it directly once the request toggle has
// been synchronised.
module cl_cmd_sync (
   input  logic        bus_clk,
   input  logic        bus_rst,
   input  logic        cl_clk,
   input  logic        cl_rst,
   input  logic        pc_msg_pending,
   input  logic [31:0] pc_msg,
   output logic        pc_msg_ack,
   output logic        cmd_valid,
   output logic [31:0] cmd_data
);

   logic        req_tog_q;
   logic        in_flight_q;
   logic        ack_q;
   logic [31:0] hold_q;
   logic [1:0]  ack_sync_q;
   logic [1:0]  req_sync_q;
   logic        ack_tog_q;
   logic        accept;

   assign accept = pc_msg_pending && !in_flight_q;

   // Bus side: accept a word, flip the request toggle, wait for the echo.
   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         req_tog_q   <= 1'b0;
         in_flight_q <= 1'b0;
         ack_q       <= 1'b0;
         hold_q      <= '0;
         ack_sync_q  <= '0;
      end else begin
         ack_sync_q <= {ack_sync_q[0], ack_tog_q};
         ack_q      <= accept;
         if (accept) begin
            hold_q      <= pc_msg;
            req_tog_q   <= ~req_tog_q;
            in_flight_q <= 1'b1;
         end else if (in_flight_q && (ack_sync_q[1] == req_tog_q)) begin
            in_flight_q <= 1'b0;
         end
      end
   end

   // Pixel side: synchronise the request and echo it back as the ack toggle.
   always_ff @(posedge cl_clk or posedge cl_rst) begin
      if (cl_rst) begin
         req_sync_q <= '0;
         ack_tog_q  <= 1'b0;
      end else begin
         req_sync_q <= {req_sync_q[0], req_tog_q};
         ack_tog_q  <= req_sync_q[1];
      end
   end

   assign pc_msg_ack = ack_q;
   assign cmd_valid  = req_sync_q[1] ^ ack_tog_q;
   assign cmd_data   = hold_q;

endmodule

// File: rtl/cl_grabber.sv
// Camera Link frame grabber: takes start/abort commands from the PC bus,
// captures whole frames and emits one 128-bit message per valid pixel beat.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | nothing armed, no messages
// ST_WAIT_LOW | armed, waiting for fval low so a partial frame is skipped
// ST_ARMED    | waiting for fval rising edge
// ST_CAPTURE  | inside a captured frame, emitting messages
module cl_grabber
   import cl_pkg::*;
#(
   parameter int N_HB_BITS    = 24,
   parameter int MAX_FRAMES_W = 20
) (
   input  logic               bus_clk,
   input  logic               reset,
   input  logic               cl_clk,
   input  logic               pc_msg_pending,
   input  logic [31:0]        pc_msg,
   output logic               pc_msg_ack,
   input  logic               cl_fval,
   input  logic               cl_lval,
   input  logic [TAP_W-1:0]   cl_data_top,
   input  logic [TAP_W-1:0]   cl_data_btm,
   input  logic               fpga_msg_full,
   output logic [MSG_W-1:0]   fpga_msg,
   output logic               fpga_msg_valid,
   output logic [2:0]         led
);

   logic [1:0]              bus_rst_q;
   logic [1:0]              cl_rst_q;
   logic                    bus_rst;
   logic                    cl_rst;

   logic                    cmd_valid;
   logic [31:0]             cmd_data;
   logic [11:0]             cmd_op;
   logic [19:0]             cmd_arg;
   logic [MAX_FRAMES_W-1:0] cmd_n;
   logic                    cmd_start;
   logic                    cmd_abort;
   logic                    cmd_stop;

   logic                    fval_q, lval_q, fval_p_q, lval_p_q;
   logic [TAP_W-1:0]        top_q, btm_q;
   logic                    fval_rise, fval_fall, lval_rise, lval_fall;

   cl_state_e               state_q;
   logic [MAX_FRAMES_W-1:0] remaining_q;
   logic [CNT_W-1:0]        frame_q;
   logic [CNT_W-1:0]        line_q, col_q;
   logic [CNT_W-1:0]        line_cur, col_cur;
   logic                    in_frame, beat;

   logic [MSG_W-1:0]        msg_q;
   logic                    msg_valid_q;
   logic                    ovf_q;
   logic [N_HB_BITS-1:0]    hb_q;

   // Reset synchronisers: assert immediately, release two clocks later.
   always_ff @(posedge bus_clk or posedge reset) begin
      if (reset) bus_rst_q <= 2'b11;
      else       bus_rst_q <= {bus_rst_q[0], 1'b0};
   end

   // Same release sequencing for the pixel clock domain.
   always_ff @(posedge cl_clk or posedge reset) begin
      if (reset) cl_rst_q <= 2'b11;
      else       cl_rst_q <= {cl_rst_q[0], 1'b0};
   end

   assign bus_rst = bus_rst_q[1];
   assign cl_rst  = cl_rst_q[1];

   cl_cmd_sync u_cmd_sync (
      .bus_clk        (bus_clk),
      .bus_rst        (bus_rst),
      .cl_clk         (cl_clk),
      .cl_rst         (cl_rst),
      .pc_msg_pending (pc_msg_pending),
      .pc_msg         (pc_msg),
      .pc_msg_ack     (pc_msg_ack),
      .cmd_valid      (cmd_valid),
      .cmd_data       (cmd_data)
   );

   assign cmd_op    = cmd_data[31:20];
   assign cmd_arg   = cmd_data[19:0];
   assign cmd_n     = MAX_FRAMES_W'(cmd_arg);
   // A start with zero frames is treated exactly like an abort.
   assign cmd_start = cmd_valid && (cmd_op == OP_START) && (cmd_n != '0);
   assign cmd_abort = cmd_valid && ((cmd_op == OP_ABORT) ||
                                    ((cmd_op == OP_START) && (cmd_n == '0)));
   assign cmd_stop  = cmd_start || cmd_abort;

   // Single register stage on the camera pins plus one delayed copy of the
   // sync flags for edge detection.
   always_ff @(posedge cl_clk or posedge cl_rst) begin
      if (cl_rst) begin
         fval_q   <= 1'b0;
         lval_q   <= 1'b0;
         fval_p_q <= 1'b0;
         lval_p_q <= 1'b0;
         top_q    <= '0;
         btm_q    <= '0;
      end else begin
         fval_q   <= cl_fval;
         lval_q   <= cl_lval;
         fval_p_q <= fval_q;
         lval_p_q <= lval_q;
         top_q    <= cl_data_top;
         btm_q    <= cl_data_btm;
      end
   end

   assign fval_rise = fval_q && !fval_p_q;
   assign fval_fall = !fval_q && fval_p_q;
   assign lval_rise = lval_q && !lval_p_q;
   assign lval_fall = !lval_q && lval_p_q;

   // The first beat of a frame can coincide with the ARMED->CAPTURE step, so
   // it counts as in-frame already.
   assign in_frame = (state_q == ST_CAPTURE) || ((state_q == ST_ARMED) && fval_rise);
   assign beat     = in_frame && fval_q && lval_q && !cmd_stop;
   assign line_cur = (state_q == ST_CAPTURE) ? line_q : '0;
   assign col_cur  = (lval_rise || (state_q != ST_CAPTURE)) ? '0 : col_q;

   // Capture sequencer with frame budget and captured-frame number.
   always_ff @(posedge cl_clk or posedge cl_rst) begin
      if (cl_rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         frame_q     <= '0;
      end else if (cmd_abort) begin
         state_q <= ST_IDLE;
      end else if (cmd_start) begin
         state_q     <= ST_WAIT_LOW;
         remaining_q <= cmd_n;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_WAIT_LOW: if (!fval_q) state_q <= ST_ARMED;
            ST_ARMED:    if (fval_rise) state_q <= ST_CAPTURE;
            ST_CAPTURE: begin
               if (fval_fall) begin
                  frame_q <= frame_q + 1'b1;
                  if (remaining_q == MAX_FRAMES_W'(1)) begin
                     state_q <= ST_IDLE;
                  end else begin
                     remaining_q <= remaining_q - 1'b1;
                     state_q     <= ST_ARMED;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Line/column counters, message output and overflow flag. The full flag
   // is taken at the write edge itself so it matches the FIFO it guards.
   always_ff @(posedge cl_clk or posedge cl_rst) begin
      if (cl_rst) begin
         line_q      <= '0;
         col_q       <= '0;
         msg_q       <= '0;
         msg_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         hb_q        <= '0;
      end else begin
         hb_q        <= hb_q + 1'b1;
         msg_valid_q <= 1'b0;
         if (state_q != ST_CAPTURE) line_q <= '0;
         else if (lval_fall)        line_q <= line_q + 1'b1;
         if (beat) begin
            col_q <= col_cur + 1'b1;
            if (fpga_msg_full) begin
               ovf_q <= 1'b1;
            end else begin
               msg_valid_q <= 1'b1;
               msg_q       <= cl_pack_msg(frame_q, line_cur, col_cur, btm_q, top_q);
            end
         end
      end
   end

   assign fpga_msg       = msg_q;
   assign fpga_msg_valid = msg_valid_q;
   assign led            = {hb_q[N_HB_BITS-1], ovf_q, (state_q != ST_IDLE)};

endmodule

// File: tb/tb_cl_grabber.sv
// Directed bench for cl_grabber with a message scoreboard.
module tb_cl_grabber;
   import cl_pkg::*;

   logic          bus_clk = 1'b0;
   logic          cl_clk  = 1'b0;
   logic          reset;
   logic          pc_msg_pending;
   logic [31:0]   pc_msg;
   logic          pc_msg_ack;
   logic          cl_fval, cl_lval;
   logic [39:0]   cl_data_top, cl_data_btm;
   logic          fpga_msg_full;
   logic [127:0]  fpga_msg;
   logic          fpga_msg_valid;
   logic [2:0]    led;

   int            tests_run = 0;
   int            fails     = 0;
   int            rx_count  = 0;
   int            exp_frame = 0;
   bit            sb_off    = 1'b0;
   logic [127:0]  exp_q[$];
   logic [127:0]  last_msg = '0;

   always #5 bus_clk = ~bus_clk;
   always #6 cl_clk  = ~cl_clk;

   cl_grabber #(.N_HB_BITS(8), .MAX_FRAMES_W(20)) dut (
      .bus_clk        (bus_clk),
      .reset          (reset),
      .cl_clk         (cl_clk),
      .pc_msg_pending (pc_msg_pending),
      .pc_msg         (pc_msg),
      .pc_msg_ack     (pc_msg_ack),
      .cl_fval        (cl_fval),
      .cl_lval        (cl_lval),
      .cl_data_top    (cl_data_top),
      .cl_data_btm    (cl_data_btm),
      .fpga_msg_full  (fpga_msg_full),
      .fpga_msg       (fpga_msg),
      .fpga_msg_valid (fpga_msg_valid),
      .led            (led)
   );

   // Monitor: every valid beat is popped from the scoreboard and compared.
   always @(negedge cl_clk) begin
      logic [127:0] exp;
      if (fpga_msg_valid === 1'b1) begin
         rx_count++;
         last_msg = fpga_msg;
         if (!sb_off) begin
            tests_run++;
            assert (exp_q.size() != 0)
            else begin
               fails++;
               $error("FAIL msg_unexpected got %h exp none", fpga_msg);
            end
            if (exp_q.size() != 0) begin
               exp = exp_q.pop_front();
               tests_run++;
               assert (fpga_msg === exp)
               else begin
                  fails++;
                  $error("FAIL msg_data got %h exp %h", fpga_msg, exp);
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic chki(input string tag, input int got, input int exp);
      tests_run++;
      assert (got == exp)
      else begin
         fails++;
         $error("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic send_cmd(input logic [31:0] msg);
      int n;
      @(negedge bus_clk);
      pc_msg         = msg;
      pc_msg_pending = 1'b1;
      n = 0;
      while (pc_msg_ack !== 1'b1 && n < 50) begin
         @(negedge bus_clk);
         n++;
      end
      chk("ack_seen", 128'(pc_msg_ack), 128'(1));
      @(negedge bus_clk);
      chk("ack_single", 128'(pc_msg_ack), 128'(0));
      @(negedge bus_clk);
      chk("ack_blocked_in_flight", 128'(pc_msg_ack), 128'(0));
      pc_msg_pending = 1'b0;
      repeat (10) @(negedge cl_clk);
   endtask

   // Drives one frame; drop_line selects a line where columns 100..109 meet
   // a full FIFO at their write edge.
   task automatic drive_frame(input int lines, input int beats, input bit capture,
                              input bit fixed, input int drop_line);
      logic [39:0] t, b;
      @(negedge cl_clk);
      cl_fval = 1'b1;
      cl_lval = 1'b0;
      @(negedge cl_clk);
      for (int l = 0; l < lines; l++) begin
         for (int c = 0; c < beats; c++) begin
            @(negedge cl_clk);
            if (fixed) begin
               t = 40'h0E0D0C0B0A;
               b = 40'h070106090F;
            end else begin
               t = {8'(c), 32'($urandom)};
               b = {8'(l), 32'($urandom)};
            end
            cl_lval       = 1'b1;
            cl_data_top   = t;
            cl_data_btm   = b;
            fpga_msg_full = (l == drop_line) && (c - 1 >= 100) && (c - 1 <= 109);
            if (capture && !((l == drop_line) && (c >= 100) && (c <= 109)))
               exp_q.push_back({16'(exp_frame), 16'(l), 16'(c), b, t});
         end
         repeat (4) begin
            @(negedge cl_clk);
            cl_lval       = 1'b0;
            fpga_msg_full = 1'b0;
         end
      end
      @(negedge cl_clk);
      cl_fval = 1'b0;
      repeat (4) @(negedge cl_clk);
      if (capture) exp_frame++;
   endtask

   initial begin
      int r0, snap, n;
      reset          = 1'b0;
      pc_msg_pending = 1'b0;
      pc_msg         = '0;
      cl_fval        = 1'b0;
      cl_lval        = 1'b0;
      cl_data_top    = '0;
      cl_data_btm    = '0;
      fpga_msg_full  = 1'b0;

      // Reset values, both while asserted and after release.
      #2 reset = 1'b1;
      #40;
      chk("rst_ack", 128'(pc_msg_ack), 128'(0));
      chk("rst_valid", 128'(fpga_msg_valid), 128'(0));
      chk("rst_msg", fpga_msg, 128'(0));
      chk("rst_led", 128'(led), 128'(0));
      reset = 1'b0;
      repeat (6) @(negedge cl_clk);
      chk("post_rst_led", 128'(led), 128'(0));
      chk("post_rst_valid", 128'(fpga_msg_valid), 128'(0));
      chk("post_rst_ack", 128'(pc_msg_ack), 128'(0));

      // Heartbeat: 8-bit divider MSB stays high for 128 cycles.
      n = 0;
      while (led[2] !== 1'b1 && n < 400) begin @(negedge cl_clk); n++; end
      chk("hb_rise", 128'(led[2]), 128'(1));
      n = 0;
      while (led[2] === 1'b1 && n < 400) begin @(negedge cl_clk); n++; end
      chki("hb_half_period", n, 128);

      // Start one frame, capture 4 x 1000 constant-data frame.
      send_cmd(32'h0010_0001);
      chki("led0_armed", int'(led[0]), 1);
      r0 = rx_count;
      drive_frame(4, 1000, 1'b1, 1'b1, -1);
      chki("frameA_count", rx_count - r0, 4000);
      chki("frameA_last_col", int'(last_msg[95:80]), 999);
      chki("frameA_last_line", int'(last_msg[111:96]), 3);
      chki("led0_after_frame", int'(led[0]), 0);
      chki("led1_no_overflow", int'(led[1]), 0);

      // Budget exhausted: next frame is ignored.
      r0 = rx_count;
      drive_frame(2, 20, 1'b0, 1'b0, -1);
      chki("idle_no_msgs", rx_count - r0, 0);

      // Start arrives mid-frame: the partial frame is skipped.
      r0 = rx_count;
      fork
         drive_frame(3, 50, 1'b0, 1'b0, -1);
         begin
            repeat (20) @(negedge cl_clk);
            send_cmd(32'h0010_0002);
         end
      join
      chki("midframe_start_no_msgs", rx_count - r0, 0);
      chki("led0_waiting", int'(led[0]), 1);

      // Frame with 10 dropped beats, then a random-data frame; N=2 done.
      r0 = rx_count;
      drive_frame(3, 200, 1'b1, 1'b0, 1);
      chki("drop_frame_count", rx_count - r0, 590);
      chki("led1_overflow", int'(led[1]), 1);
      r0 = rx_count;
      drive_frame(3, 30, 1'b1, 1'b0, -1);
      chki("rand_frame_count", rx_count - r0, 90);
      chki("led0_done_n2", int'(led[0]), 0);

      // Abort mid-frame: output stops, FSM back to IDLE.
      send_cmd(32'h0010_0005);
      sb_off = 1'b1;
      r0   = rx_count;
      snap = r0;
      fork
         drive_frame(4, 100, 1'b0, 1'b0, -1);
         begin
            repeat (150) @(negedge cl_clk);
            send_cmd(32'h0000_0000);
            repeat (4) @(negedge cl_clk);
            snap = rx_count;
         end
      join
      sb_off = 1'b0;
      chki("abort_had_msgs", int'(snap > r0), 1);
      chki("abort_stops_msgs", rx_count - snap, 0);
      chki("led0_after_abort", int'(led[0]), 0);
      r0 = rx_count;
      drive_frame(1, 10, 1'b0, 1'b0, -1);
      chki("abort_idle_no_msgs", rx_count - r0, 0);

      // Unknown opcode is acked and ignored.
      send_cmd(32'h0050_0003);
      chki("unknown_op_idle", int'(led[0]), 0);

      // Fresh capture after abort: frame number continues at 3.
      send_cmd(32'h0010_0001);
      r0 = rx_count;
      drive_frame(2, 16, 1'b1, 1'b0, -1);
      chki("final_frame_count", rx_count - r0, 32);
      chki("final_frame_num", int'(last_msg[127:112]), 3);
      chki("sb_empty", exp_q.size(), 0);
      chki("led1_sticky", int'(led[1]), 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
